// File: rtl/truth_table_checker.sv
// Exhaustive equivalence checker: sweeps every N-bit input vector through a
// logic block and compares its two outputs after a programmable settle time.
module truth_table_checker #(
  parameter int unsigned N      = 2,
  parameter int unsigned SETTLE = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         abort,
  output logic [N-1:0] vec,
  input  logic         s1,
  input  logic         s2,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [N:0]   mismatch_count,
  output logic         first_fail_valid,
  output logic [N-1:0] first_fail_vec
);

  localparam int unsigned CW = 4;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DRIVE  = 2'd1;
  localparam logic [1:0] S_SAMPLE = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [N-1:0] VEC_LAST    = '1;
  localparam logic [N-1:0] VEC_ONE     = N'(1);
  localparam logic [N:0]   MC_ONE      = (N+1)'(1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);
  localparam logic [CW-1:0] SETTLE_ONE  = CW'(1);

  logic [1:0]    r_state,  w_state_nxt;
  logic [N-1:0]  r_vec,    w_vec_nxt;
  logic [CW-1:0] r_settle, w_settle_nxt;
  logic [N:0]    r_mcount, w_mcount_nxt;
  logic          r_ffv,    w_ffv_nxt;
  logic [N-1:0]  r_ffvec,  w_ffvec_nxt;

  // State and result registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_vec    <= '0;
      r_settle <= '0;
      r_mcount <= '0;
      r_ffv    <= 1'b0;
      r_ffvec  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_vec    <= w_vec_nxt;
      r_settle <= w_settle_nxt;
      r_mcount <= w_mcount_nxt;
      r_ffv    <= w_ffv_nxt;
      r_ffvec  <= w_ffvec_nxt;
    end
  end

  // Next-state and datapath; abort wins over start and over the sample compare
  always_comb begin
    w_state_nxt  = r_state;
    w_vec_nxt    = r_vec;
    w_settle_nxt = r_settle;
    w_mcount_nxt = r_mcount;
    w_ffv_nxt    = r_ffv;
    w_ffvec_nxt  = r_ffvec;

    case (r_state)
      S_IDLE, S_DONE: begin
        if (start && !abort) begin
          w_state_nxt  = S_DRIVE;
          w_vec_nxt    = '0;
          w_settle_nxt = '0;
          w_mcount_nxt = '0;
          w_ffv_nxt    = 1'b0;
          w_ffvec_nxt  = '0;
        end
      end
      S_DRIVE: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_settle_nxt = r_settle + SETTLE_ONE;
          if (r_settle == SETTLE_LAST) begin
            w_state_nxt = S_SAMPLE;
          end
        end
      end
      S_SAMPLE: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else begin
          if (s1 != s2) begin
            w_mcount_nxt = r_mcount + MC_ONE;
            if (!r_ffv) begin
              w_ffv_nxt   = 1'b1;
              w_ffvec_nxt = r_vec;
            end
          end
          if (r_vec == VEC_LAST) begin
            w_state_nxt = S_DONE;
          end else begin
            w_vec_nxt    = r_vec + VEC_ONE;
            w_settle_nxt = '0;
            w_state_nxt  = S_DRIVE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign vec              = r_vec;
  assign busy             = (r_state == S_DRIVE) || (r_state == S_SAMPLE);
  assign done             = (r_state == S_DONE);
  assign pass             = (r_state == S_DONE) && (r_mcount == '0);
  assign mismatch_count   = r_mcount;
  assign first_fail_valid = r_ffv;
  assign first_fail_vec   = r_ffvec;

endmodule

// File: tb/tb_truth_table_checker.sv
// Bench for truth_table_checker: drives two instances (SETTLE=1 and SETTLE=3)
// with fixed and random two-input functions against a truth-table model.
module tb_truth_table_checker;

  localparam int unsigned N  = 2;
  localparam int unsigned NV = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic          reset_a, start_a, abort_a, s1_a, s2_a, busy_a, done_a, pass_a, ffv_a;
  logic [N-1:0]  vec_a, ffvec_a;
  logic [N:0]    mc_a;
  logic [1:0]    mode_a;
  logic [NV-1:0] tt1_a, tt2_a;

  logic          reset_b, start_b, abort_b, s1_b, s2_b, busy_b, done_b, pass_b, ffv_b;
  logic [N-1:0]  vec_b, ffvec_b;
  logic [N:0]    mc_b;
  logic [1:0]    mode_b;
  logic [NV-1:0] tt1_b, tt2_b;

  // mode 0: equivalent pair, mode 1: x&~y vs x|y, mode 2: arbitrary truth tables
  function automatic logic fn_s1(input logic [1:0] mode, input logic [NV-1:0] tt, input logic [N-1:0] v);
    logic x, y;
    x = v[1];
    y = v[0];
    case (mode)
      2'd0:    return ~(~x & ~y) & (x | y);
      2'd1:    return x & ~y;
      default: return tt[v];
    endcase
  endfunction

  function automatic logic fn_s2(input logic [1:0] mode, input logic [NV-1:0] tt, input logic [N-1:0] v);
    logic x, y;
    x = v[1];
    y = v[0];
    case (mode)
      2'd0, 2'd1: return x | y;
      default:    return tt[v];
    endcase
  endfunction

  assign s1_a = fn_s1(mode_a, tt1_a, vec_a);
  assign s2_a = fn_s2(mode_a, tt2_a, vec_a);
  assign s1_b = fn_s1(mode_b, tt1_b, vec_b);
  assign s2_b = fn_s2(mode_b, tt2_b, vec_b);

  truth_table_checker #(.N(N), .SETTLE(1)) dut_a (
    .clk(clk), .reset(reset_a), .start(start_a), .abort(abort_a), .vec(vec_a),
    .s1(s1_a), .s2(s2_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .mismatch_count(mc_a), .first_fail_valid(ffv_a), .first_fail_vec(ffvec_a)
  );

  truth_table_checker #(.N(N), .SETTLE(3)) dut_b (
    .clk(clk), .reset(reset_b), .start(start_b), .abort(abort_b), .vec(vec_b),
    .s1(s1_b), .s2(s2_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .mismatch_count(mc_b), .first_fail_valid(ffv_b), .first_fail_vec(ffvec_b)
  );

  // Expected sweep results: walk the whole truth table
  task automatic model(input logic [1:0] mode, input logic [NV-1:0] t1, input logic [NV-1:0] t2,
                       output int cnt, output logic ffv, output logic [N-1:0] ffvec);
    cnt   = 0;
    ffv   = 1'b0;
    ffvec = '0;
    for (int v = 0; v < int'(NV); v++) begin
      if (fn_s1(mode, t1, N'(v)) != fn_s2(mode, t2, N'(v))) begin
        if (!ffv) begin
          ffv   = 1'b1;
          ffvec = N'(v);
        end
        cnt++;
      end
    end
  endtask

  task automatic sweep_a(input string name, input int inj_k);
    int cnt;
    logic effv;
    logic [N-1:0] efv;
    model(mode_a, tt1_a, tt2_a, cnt, effv, efv);
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    for (int k = 0; k < int'(NV) * 2; k++) begin
      checks++;
      if (vec_a !== N'(k / 2) || busy_a !== 1'b1 || done_a !== 1'b0) begin
        errors++;
        $display("FAIL %s cyc%0d: vec=%0d busy=%b done=%b, expected vec=%0d busy=1 done=0",
                 name, k, vec_a, busy_a, done_a, k / 2);
      end
      if (k == inj_k) start_a = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0;
    end
    checks++;
    if (done_a !== 1'b1 || busy_a !== 1'b0 || pass_a !== (cnt == 0)) begin
      errors++;
      $display("FAIL %s end: done=%b busy=%b pass=%b, expected done=1 busy=0 pass=%b",
               name, done_a, busy_a, pass_a, cnt == 0);
    end
    checks++;
    if (mc_a !== (N+1)'(cnt) || ffv_a !== effv || ffvec_a !== efv) begin
      errors++;
      $display("FAIL %s results: count=%0d ffv=%b ffvec=%0d, expected count=%0d ffv=%b ffvec=%0d",
               name, mc_a, ffv_a, ffvec_a, cnt, effv, efv);
    end
  endtask

  task automatic sweep_b(input string name);
    int cnt;
    logic effv;
    logic [N-1:0] efv;
    int cyc;
    model(mode_b, tt1_b, tt2_b, cnt, effv, efv);
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    cyc = 1;
    while (done_b !== 1'b1 && cyc < 40) begin
      if (vec_b !== N'((cyc - 1) / 4) || busy_b !== 1'b1) begin
        checks++;
        errors++;
        $display("FAIL %s cyc%0d: vec=%0d busy=%b, expected vec=%0d busy=1",
                 name, cyc - 1, vec_b, busy_b, (cyc - 1) / 4);
      end
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (cyc - 1 != 16 || done_b !== 1'b1) begin
      errors++;
      $display("FAIL %s latency: done=%b after %0d cycles, expected done=1 after 16", name, done_b, cyc - 1);
    end
    checks++;
    if (mc_b !== (N+1)'(cnt) || ffv_b !== effv || ffvec_b !== efv || pass_b !== (cnt == 0)) begin
      errors++;
      $display("FAIL %s results: count=%0d ffv=%b ffvec=%0d pass=%b, expected %0d %b %0d %b",
               name, mc_b, ffv_b, ffvec_b, pass_b, cnt, effv, efv, cnt == 0);
    end
  endtask

  task automatic check_a_zero(input string name);
    checks++;
    if (vec_a !== '0 || busy_a !== 1'b0 || done_a !== 1'b0 || pass_a !== 1'b0 ||
        mc_a !== '0 || ffv_a !== 1'b0 || ffvec_a !== '0) begin
      errors++;
      $display("FAIL %s: vec=%0d busy=%b done=%b pass=%b count=%0d ffv=%b ffvec=%0d, expected all 0",
               name, vec_a, busy_a, done_a, pass_a, mc_a, ffv_a, ffvec_a);
    end
  endtask

  task automatic test_reset();
    reset_a = 1'b1; reset_b = 1'b1;
    start_a = 1'b0; start_b = 1'b0; abort_a = 1'b0; abort_b = 1'b0;
    mode_a = 2'd0; mode_b = 2'd0; tt1_a = '0; tt2_a = '0; tt1_b = '0; tt2_b = '0;
    #1;
    check_a_zero("reset_async");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_a = 1'b0; reset_b = 1'b0;
    @(posedge clk); #1;
    check_a_zero("reset_idle");
  endtask

  task automatic test_equiv();
    mode_a = 2'd0;
    sweep_a("equiv", -1);
  endtask

  task automatic test_nonequiv();
    mode_a = 2'd1;
    sweep_a("nonequiv", -1);
  endtask

  task automatic test_start_while_busy();
    mode_a = 2'd1;
    sweep_a("start_busy", 3);
  endtask

  task automatic test_restart();
    mode_a = 2'd1;
    sweep_a("restart_first", -1);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (done_a !== 1'b1 || mc_a !== 3'd2 || vec_a !== 2'd3 || ffvec_a !== 2'd1) begin
      errors++;
      $display("FAIL done_hold: done=%b count=%0d vec=%0d ffvec=%0d, expected 1 2 3 1",
               done_a, mc_a, vec_a, ffvec_a);
    end
    mode_a = 2'd0;
    sweep_a("restart_second", -1);
  endtask

  task automatic test_abort();
    mode_a = 2'd2; tt1_a = 4'b0000; tt2_a = 4'b1111;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    abort_a = 1'b1;
    @(posedge clk); #1;
    abort_a = 1'b0;
    checks++;
    if (busy_a !== 1'b0 || done_a !== 1'b0 || vec_a !== 2'd2 || mc_a !== 3'd2 ||
        ffv_a !== 1'b1 || ffvec_a !== 2'd0) begin
      errors++;
      $display("FAIL abort: busy=%b done=%b vec=%0d count=%0d ffv=%b ffvec=%0d, expected 0 0 2 2 1 0",
               busy_a, done_a, vec_a, mc_a, ffv_a, ffvec_a);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy_a !== 1'b0 || vec_a !== 2'd2 || mc_a !== 3'd2) begin
      errors++;
      $display("FAIL abort_hold: busy=%b vec=%0d count=%0d, expected 0 2 2", busy_a, vec_a, mc_a);
    end
  endtask

  task automatic test_reset_mid();
    mode_a = 2'd2; tt1_a = 4'b0000; tt2_a = 4'b1111;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset_a = 1'b1;
    #1;
    check_a_zero("reset_mid");
    @(posedge clk);
    @(negedge clk);
    reset_a = 1'b0;
    sweep_a("post_reset", -1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      mode_a = 2'd2;
      tt1_a = NV'($urandom);
      tt2_a = (i == 0) ? tt1_a : NV'($urandom);
      sweep_a("random_a", -1);
    end
  endtask

  task automatic test_settle3();
    mode_b = 2'd0;
    sweep_b("settle3_equiv");
    mode_b = 2'd1;
    sweep_b("settle3_nonequiv");
    for (int i = 0; i < 3; i++) begin
      mode_b = 2'd2;
      tt1_b = NV'($urandom);
      tt2_b = NV'($urandom);
      sweep_b("settle3_random");
    end
  endtask

  initial begin
    test_reset();
    test_equiv();
    test_nonequiv();
    test_start_while_busy();
    test_restart();
    test_abort();
    test_reset_mid();
    test_random();
    test_settle3();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
